uart_rx_sampler: RTL

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler_if.sv | 24 ++
 rtl/uart_rx_sampler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: groups the oversample clock, serial line, read
// acknowledge and receive status/data signals of uart_rx_sampler.
// master: the side that feeds the line and consumes words.
// slave : the receiver itself.
interface uart_rx_sampler_if;
    logic       os_clk;
    logic       rx;
    logic       rd;
    logic [7:0] data;
    logic       rx_avail;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    modport master (
        output os_clk, rx, rd,
        input  data, rx_avail, frame_error, overrun, parity_error
    );

    modport slave (
        input  os_clk, rx, rd,
        output data, rx_avail, frame_error, overrun, parity_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampling UART receiver.
// Samples the start bit mid-bit, then every 16 ticks for each data bit,
// optional parity bit and the stop bit. All state advances only on the
// rising edge of os_clk seen in the clk domain, so a stalled os_clk
// freezes the receiver.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// before the stop bit; otherwise parity_error is tied low.
module uart_rx_sampler #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_sampler_if.slave bus
);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rxs;
    logic                 line_prev;
    logic                 os_clk_q;
    logic                 tick;
    logic [3:0]           tick_cnt, tick_cnt_n;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 complete;
    logic                 stop_bad;
    logic [7:0]           data_r;
    logic                 avail_r;
    logic                 overrun_r;
    logic                 ferr_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_n;
    logic                 perr_r;
`endif

    assign tick = bus.os_clk & ~os_clk_q;

    // Two-flop synchronizer for rx and rising-edge capture of os_clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            os_clk_q <= 1'b0;
        end else begin
            rx_meta  <= bus.rx;
            rxs      <= rx_meta;
            os_clk_q <= bus.os_clk;
        end
    end

    // Tick-rate line history for start detection; cleared on reset so a
    // line already low when reset is released is not taken as a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       line_prev <= 1'b0;
        else if (tick) line_prev <= rxs;
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bad  <= par_bad_n;
`endif
        end
    end

    // Next-state logic: every decision is taken on a tick only.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        complete   = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
`endif
        if (tick) begin
            tick_cnt_n = tick_cnt + 4'd1;
            case (state)
                IDLE: begin
                    if (line_prev && !rxs) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        par_bad_n  = 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n   = PARITY;
`else
                            state_n   = STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        par_bad_n = rxs ^ (^shreg);
                        state_n   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        state_n  = IDLE;
                        complete = rxs;
                        stop_bad = ~rxs;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output registers: word store, availability/overrun handshake, pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r    <= '0;
            avail_r   <= 1'b0;
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            ferr_r <= stop_bad;
            if (complete) begin
                data_r  <= 8'(shreg);
                avail_r <= 1'b1;
                if (avail_r && !bus.rd) overrun_r <= 1'b1;
            end else if (bus.rd && avail_r) begin
                avail_r   <= 1'b0;
                overrun_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulses in the completion cycle of a frame with good stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_r <= 1'b0;
        else     perr_r <= complete & par_bad;
    end

    assign bus.parity_error = perr_r;
`else
    assign bus.parity_error = 1'b0;
`endif

    assign bus.data        = data_r;
    assign bus.rx_avail    = avail_r;
    assign bus.overrun     = overrun_r;
    assign bus.frame_error = ferr_r;
endmodule
